// File: rtl/fp32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp32_pkg : binary32 field constants and operand unpack helper         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fp32_pkg;

  localparam int          EXP_W   = 8;
  localparam int          FRAC_W  = 23;
  localparam int          BIAS    = 127;
  localparam logic [7:0]  EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  // Significand plus guard/round/sticky, with one extra bit for the add carry
  localparam int SUM_W = FRAC_W + 1 + 3 + 1;
  localparam int LZC_W = 5;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [FRAC_W:0]   sig;
  } fp_unpacked_t;

  // Subnormals get effective exponent 1 and a zero hidden bit
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] v);
    fp_unpacked_t u;
    u.sign = v[31];
    u.expo = (v[30:23] == 8'd0) ? 8'd1 : v[30:23];
    u.sig  = {(v[30:23] != 8'd0), v[22:0]};
    return u;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_lzc : leading-zero counter for the normalization shifter           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fp_lzc
  import fp32_pkg::*;
(
  input  logic [SUM_W-1:0] data_i,
  output logic [LZC_W-1:0] count_o
);

  // Ascending scan: the highest set bit is the last one to write the count
  always_comb begin
    count_o = LZC_W'(SUM_W);
    for (int i = 0; i < SUM_W; i++) begin
      if (data_i[i]) count_o = LZC_W'(SUM_W - 1 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp32_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp32_adder : combinational binary32 adder (RNE, subnormals) with a    |
// |              registered overflow flag.  Rev 1.0                       |
// +----------------------------------------------------------------------+
module fp32_adder
  import fp32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] result,
  output logic             overflow_flag
);

  fp_unpacked_t ux, uy, a, b;
  logic         x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
  logic         swap, eff_sub;
  logic [7:0]   exp_diff;
  logic [26:0]  b_ext, b_al, lost_mask;
  logic [SUM_W-1:0] sum;
  logic [LZC_W-1:0] lz;
  logic [7:0]   lz27, shift_max, shift;
  logic [26:0]  norm;
  logic [9:0]   exp_n, exp_f;
  logic         round_up, ovf_arith, ovf_now;
  logic [24:0]  mant_r;
  logic [22:0]  frac_f;
  logic [7:0]   exp_field;
  logic         overflow_d, overflow_q;

  assign x_nan  = (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
  assign y_nan  = (y[30:23] == EXP_MAX) && (y[22:0] != 23'd0);
  assign x_inf  = (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
  assign y_inf  = (y[30:23] == EXP_MAX) && (y[22:0] == 23'd0);
  assign x_zero = (x[30:0] == 31'd0);
  assign y_zero = (y[30:0] == 31'd0);

  assign ux   = fp_unpack(x);
  assign uy   = fp_unpack(y);
  assign swap = {uy.expo, uy.sig} > {ux.expo, ux.sig};
  assign a    = swap ? uy : ux;
  assign b    = swap ? ux : uy;

  assign exp_diff = a.expo - b.expo;
  assign b_ext    = {b.sig, 3'b000};
  assign eff_sub  = a.sign ^ b.sign;

  // Shifted-out bits of B collapse into the sticky position
  always_comb begin
    lost_mask = '0;
    if (exp_diff >= 8'd27) begin
      b_al = {26'd0, |b_ext};
    end else begin
      lost_mask = (27'd1 << exp_diff) - 27'd1;
      b_al      = (b_ext >> exp_diff) | {26'd0, |(b_ext & lost_mask)};
    end
  end

  assign sum = eff_sub ? ({1'b0, a.sig, 3'b000} - {1'b0, b_al})
                       : ({1'b0, a.sig, 3'b000} + {1'b0, b_al});

  fp_lzc u_lzc (
    .data_i  (sum),
    .count_o (lz)
  );

  assign lz27      = {3'd0, lz} - 8'd1;
  assign shift_max = a.expo - 8'd1;
  assign shift     = (lz27 > shift_max) ? shift_max : lz27;

  // Left shift is capped at exponent 1; a still-clear hidden bit means subnormal
  always_comb begin
    if (sum[SUM_W-1]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      exp_n = {2'b00, a.expo} + 10'd1;
    end else begin
      norm  = sum[26:0] << shift;
      exp_n = {2'b00, a.expo - shift};
    end
  end

  assign round_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign mant_r    = {1'b0, norm[26:3]} + {24'd0, round_up};
  assign exp_f     = exp_n + {9'd0, mant_r[24]};
  assign ovf_arith = (exp_f >= 10'd255);
  assign frac_f    = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
  assign exp_field = (mant_r[24] | mant_r[23]) ? exp_f[7:0] : 8'd0;

  always_comb begin
    if (x_nan || y_nan) begin
      result = QNAN;
    end else if (x_inf && y_inf && (x[31] != y[31])) begin
      result = QNAN;
    end else if (x_inf) begin
      result = x[31] ? NEG_INF : POS_INF;
    end else if (y_inf) begin
      result = y[31] ? NEG_INF : POS_INF;
    end else if (x_zero && y_zero) begin
      result = {x[31] & y[31], 31'd0};
    end else if (sum == '0) begin
      result = 32'd0;
    end else if (ovf_arith) begin
      result = a.sign ? NEG_INF : POS_INF;
    end else begin
      result = {a.sign, exp_field, frac_f};
    end
  end

  assign ovf_now    = !(x_nan || y_nan || x_inf || y_inf) && (sum != '0) && ovf_arith;
  assign overflow_d = ovf_now;

  always_ff @(posedge clk) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign overflow_flag = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fp32_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp32_adder : directed self-checking bench for fp32_adder           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_fp32_adder;

  logic        clk;
  logic        rst;
  logic [31:0] x;
  logic [31:0] y;
  logic [31:0] result;
  logic        overflow_flag;

  int checks = 0;
  int errors = 0;

  fp32_adder #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .x             (x),
    .y             (y),
    .result        (result),
    .overflow_flag (overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; x = 32'd0; y = 32'd0;
    @(posedge clk); #1;
    checks++;
    if (overflow_flag !== 1'b0) begin
      errors++; $display("FAIL reset_flag got %b want 0", overflow_flag);
    end
    checks++;
    if (result !== 32'h00000000) begin
      errors++; $display("FAIL reset_result got %h want 00000000", result);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_vectors(input string name, input logic [31:0] tv [0:4][0:2], input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      x = tv[i][0]; y = tv[i][1];
      #1;
      checks++;
      if (result !== tv[i][2]) begin
        errors++;
        $display("FAIL %s[%0d] %h+%h got %h want %h", name, i, tv[i][0], tv[i][1], result, tv[i][2]);
      end
    end
  endtask

  task automatic test_basics();
    logic [31:0] tv [0:4][0:2];
    tv = '{'{32'h3F800000, 32'h3F800000, 32'h40000000},
           '{32'h3F800000, 32'hBF800000, 32'h00000000},
           '{32'h3F000000, 32'h3F800000, 32'h3FC00000},
           '{32'h3F000000, 32'hBF800000, 32'hBF000000},
           '{32'h00000000, 32'h3F800000, 32'h3F800000}};
    test_vectors("basic", tv, 5);
  endtask

  task automatic test_specials();
    logic [31:0] tv [0:4][0:2];
    tv = '{'{32'h7F800000, 32'h3F800000, 32'h7F800000},
           '{32'hFF800000, 32'hBF800000, 32'hFF800000},
           '{32'h7FC00000, 32'h7FC00000, 32'h7FC00000},
           '{32'h7F800000, 32'hFF800000, 32'h7FC00000},
           '{32'h80000000, 32'h80000000, 32'h80000000}};
    test_vectors("special", tv, 5);
  endtask

  task automatic test_subnormals();
    logic [31:0] tv [0:4][0:2];
    tv = '{'{32'h00000001, 32'h00000001, 32'h00000002},
           '{32'h00000002, 32'h00000001, 32'h00000003},
           '{32'h00000001, 32'h3F000000, 32'h3F000000},
           '{32'h00800000, 32'h80800000, 32'h00000000},
           '{32'h00400000, 32'h00400000, 32'h00800000}};
    test_vectors("subnormal", tv, 5);
  endtask

  task automatic test_rounding();
    logic [31:0] tv [0:4][0:2];
    tv = '{'{32'h3F800001, 32'h3F800001, 32'h40000001},
           '{32'h3F800000, 32'h33800000, 32'h3F800000},
           '{32'h3F800001, 32'h33800000, 32'h3F800002},
           '{32'h3F800000, 32'hBF7FFFFF, 32'h33800000},
           '{32'h00000000, 32'h00000000, 32'h00000000}};
    test_vectors("round", tv, 4);
  endtask

  task automatic test_overflow_flag();
    logic [31:0] tv [0:4][0:2];
    tv = '{'{32'h7F000000, 32'h7F000000, 32'h7F800000},
           '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF800000},
           '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000},
           '{32'h00000000, 32'h00000000, 32'h00000000},
           '{32'h00000000, 32'h00000000, 32'h00000000}};
    test_vectors("ovf_result", tv, 3);
    @(posedge clk); #1;
    checks++;
    if (overflow_flag !== 1'b1) begin
      errors++; $display("FAIL ovf_flag_set got %b want 1", overflow_flag);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (overflow_flag !== 1'b0) begin
      errors++; $display("FAIL ovf_flag_rst got %b want 0", overflow_flag);
    end
    checks++;
    if (result !== 32'h7F800000) begin
      errors++; $display("FAIL ovf_result_in_rst got %h want 7f800000", result);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (overflow_flag !== 1'b1) begin
      errors++; $display("FAIL ovf_flag_reset_release got %b want 1", overflow_flag);
    end
    @(negedge clk); x = 32'h3F800000; y = 32'h3F800000;
    @(posedge clk); #1;
    checks++;
    if (overflow_flag !== 1'b0) begin
      errors++; $display("FAIL ovf_flag_clear got %b want 0", overflow_flag);
    end
    // An infinite operand is not an arithmetic overflow
    @(negedge clk); x = 32'h7F800000; y = 32'h3F800000;
    @(posedge clk); #1;
    checks++;
    if (overflow_flag !== 1'b0) begin
      errors++; $display("FAIL ovf_flag_inf_operand got %b want 0", overflow_flag);
    end
  endtask

  initial begin
    rst = 1'b1; x = 32'd0; y = 32'd0;
    test_reset();
    test_basics();
    test_specials();
    test_subnormals();
    test_rounding();
    test_overflow_flag();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp32_adder.md
Name: fp32_adder

Overview:
- Combinational IEEE-754 binary32 adder: result = x + y.
- Round-to-nearest-even, full subnormal support, IEEE special-value handling.
- Registered overflow status flag is the only clocked state.
- Used as the floating-point add datapath element in the arithmetic unit.

Parameters:
WIDTH, 32, operand/result width; only 32 (binary32) is supported.

Ports:
clk  input  1  system clock; used only by the overflow flag register
rst  input  1  synchronous, active-high reset
x  input  32  operand A, binary32 (sign[31], exp[30:23], frac[22:0])
y  input  32  operand B, binary32
result  output  32  binary32 sum; combinational from x, y
overflow_flag  output  1  registered: 1 if the previous cycle's finite operands overflowed to infinity

Behaviour:
- Clocking and reset:
  - Single clock domain: clk. rst is synchronous and active-high.
  - result is purely combinational: zero latency, valid within the same delta/settle time as x and y. It does not depend on clk or rst.
  - On each rising clk edge: overflow_flag <= rst ? 0 : ovf_now.
  - ovf_now = both operands finite and the rounded magnitude exceeds the maximum finite value (0x7F7FFFFF).
  - Reset value of overflow_flag is 0.
- Special cases (checked first, in this priority):
  - Either operand is NaN (exp = 255, frac != 0): result = 0x7FC00000 (canonical quiet NaN, sign 0).
  - +inf + -inf: result = 0x7FC00000.
  - One or both operands infinite with the same sign: result = that infinity.
  - Both zero: result = -0 only if both are -0; otherwise +0.
- Unpack:
  - Normal operand: significand = {1, frac}, exponent = exp.
  - Subnormal operand: significand = {0, frac}, effective exponent = 1.
- Align:
  - Swap so operand A has the larger magnitude (compare exponent, then significand).
  - Extend with 3 bits: guard, round, sticky.
  - Right-shift B by the exponent difference; all shifted-out bits OR into sticky.
  - A difference of 26 or more leaves B only in sticky.
- Add/subtract:
  - Same signs: add significands. Different signs: subtract B from A.
  - Result sign = sign of A.
  - Exact zero from subtraction gives +0.
- Normalize:
  - Carry out: shift right 1 (preserve sticky) and increment the exponent.
  - Otherwise left-shift by the leading-zero count, limited so the exponent does not go below 1.
  - If the hidden bit is still 0 after the limited shift, the result is subnormal and the packed exponent field is 0.
- Round:
  - Round to nearest, ties to even, using guard/round/sticky.
  - Rounding carry renormalizes: mantissa overflow increments the exponent; a subnormal that rounds up to the hidden bit becomes normal with exp = 1.
- Overflow:
  - Final exponent >= 255 gives ±infinity (exp = 255, frac = 0) and sets ovf_now.
- Sums of subnormals are exact (e.g. 0x00000002 + 0x00000001 = 0x00000003). There is no flush-to-zero.
- No exception outputs other than overflow_flag. Inexact, underflow and invalid are not reported.

Decomposition:
- Shared package fp32_pkg holds:
  - EXP_W = 8, FRAC_W = 23, BIAS = 127
  - EXP_MAX = 8'hFF
  - QNAN = 32'h7FC00000, POS_INF = 32'h7F800000, NEG_INF = 32'hFF800000
  - a struct for the unpacked operand {sign, exp, sig}
- One sub-module, fp_lzc: a 28-bit leading-zero counter feeding the normalization shifter.
- Unpack, align, add, round and pack stay inline in fp32_adder.

Test Plan:
- Basics:
  - 0x3F800000 + 0x3F800000 -> 0x40000000.
  - 0x3F800000 + 0xBF800000 -> 0x00000000.
  - 0x3F000000 + 0x3F800000 -> 0x3FC00000.
  - 0x3F000000 + 0xBF800000 -> 0xBF000000.
  - 0x00000000 + 0x3F800000 -> 0x3F800000.
- Specials:
  - 0x7F800000 + 0x3F800000 -> 0x7F800000.
  - 0xFF800000 + 0xBF800000 -> 0xFF800000.
  - 0x7FC00000 + 0x7FC00000 -> 0x7FC00000.
  - 0x7F800000 + 0xFF800000 -> 0x7FC00000.
- Subnormals:
  - 0x00000001 + 0x00000001 -> 0x00000002.
  - 0x00000002 + 0x00000001 -> 0x00000003.
  - 0x00000001 + 0x3F000000 -> 0x3F000000 (rounded away).
  - 0x00800000 + 0x80800000 -> 0x00000000.
- Rounding: 0x3F800001 + 0x3F800001 -> 0x40000001.
  - 0x3F800000 + 0x33800000 (tie) -> 0x3F800000.
  - 0x3F800001 + 0x33800000 -> 0x3F800002.
- Overflow and flag:
  - 0x7F000000 + 0x7F000000 -> 0x7F800000.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000.
  - overflow_flag = 1 after the next clk edge.
  - Assert rst for one edge: overflow_flag = 0 while result stays 0x7F800000.
  - Finite non-overflowing inputs clear the flag on the next edge.
